// File: rtl/vga_pkg.sv
// Shared timing defaults, state type and bar colours for vga_timing_gen.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } vga_state_e;

`ifdef VGA_TIMING_TESTPATTERN_EN
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction
`endif

endpackage

// File: rtl/vga_timing_gen_rgb565_expand.sv
// RGB565 to RGB888 expansion by MSB replication, so full-scale stays full-scale.
module rgb565_expand (
  input  logic [15:0] pix_i,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o
);

  assign r_o = {pix_i[15:11], pix_i[15:13]};
  assign g_o = {pix_i[10:5],  pix_i[10:9]};
  assign b_o = {pix_i[4:0],   pix_i[4:2]};

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing plus frame-locked RGB565 pixel sink (SEEK -> ARMED -> RUN).
// Define VGA_TIMING_TESTPATTERN_EN to show colour bars instead of black filler.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_start,
  output logic [15:0] underflow_cnt
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [31:0]   hpos, vpos;
  logic          active, origin, h_last, v_last;

  vga_state_e    state_q, state_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   uflow_q, uflow_d;
  logic          rdy, xfer, show_pix, uflow_inc;
  logic [15:0]   show_data;

  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, fs_q, fs_d;
  logic [23:0]   rgb_q, rgb_d, fill_rgb;
  logic [7:0]    exp_r, exp_g, exp_b;

  assign hpos   = 32'(hcnt_q);
  assign vpos   = 32'(vcnt_q);
  assign active = (hpos < H_ACTIVE) && (vpos < V_ACTIVE);
  assign origin = (hpos == 0) && (vpos == 0);
  assign h_last = (hpos == H_TOTAL - 1);
  assign v_last = (vpos == V_TOTAL - 1);

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
    end
  end

  // RUN refuses (0,0): that slot belongs to the frame-start pixel, which only ARMED delivers.
  always_comb begin
    rdy = 1'b0;
    case (state_q)
      ST_SEEK:  rdy = 1'b1;
      ST_ARMED: rdy = 1'b0;
      ST_RUN:   rdy = active && !origin;
      default:  rdy = 1'b0;
    endcase
  end

  assign xfer      = pix_valid && rdy;
  assign pix_ready = reset_n && rdy;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    show_pix  = 1'b0;
    show_data = pix_data;
    uflow_inc = 1'b0;
    case (state_q)
      ST_SEEK: begin
        if (xfer && pix_sof) begin
          hold_d  = pix_data;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (origin) begin
          show_pix  = 1'b1;
          show_data = hold_q;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer && pix_sof) begin
          hold_d  = pix_data;
          state_d = ST_ARMED;
        end else if (xfer) begin
          show_pix = 1'b1;
        end else if (rdy) begin
          uflow_inc = 1'b1;
        end
      end
      default: state_d = ST_SEEK;
    endcase
  end

  assign uflow_d = (uflow_inc && (uflow_q != 16'hFFFF)) ? uflow_q + 16'd1 : uflow_q;

  rgb565_expand u_expand (
    .pix_i (show_data),
    .r_o   (exp_r),
    .g_o   (exp_g),
    .b_o   (exp_b)
  );

`ifdef VGA_TIMING_TESTPATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (hpos >= 32'(k * BAR_W)) bar_idx = 3'(k);
  end

  // Bars must reach the monitor, so the DAC is unblanked for every active cycle.
  assign fill_rgb  = bar_rgb(bar_idx);
  assign blank_n_d = active;
`else
  logic live;

  // Unblank only while locked to a frame; an idle or seeking sink stays fully blanked.
  assign live      = (state_q == ST_RUN) || ((state_q == ST_ARMED) && origin);
  assign fill_rgb  = '0;
  assign blank_n_d = active && live;
`endif

  assign hs_d  = !((hpos >= HS_BEG) && (hpos < HS_END));
  assign vs_d  = !((vpos >= VS_BEG) && (vpos < VS_END));
  assign fs_d  = origin;
  assign rgb_d = !active ? '0 : (show_pix ? {exp_r, exp_g, exp_b} : fill_rgb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      state_q   <= ST_SEEK;
      hold_q    <= '0;
      uflow_q   <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      uflow_q   <= uflow_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
    end
  end

  assign VGA_CLK       = clk;
  assign VGA_SYNC_n    = 1'b1;
  assign VGA_HS        = hs_q;
  assign VGA_VS        = vs_q;
  assign VGA_BLANK_n   = blank_n_q;
  assign VGA_R         = rgb_q[23:16];
  assign VGA_G         = rgb_q[15:8];
  assign VGA_B         = rgb_q[7:0];
  assign frame_start   = fs_q;
  assign underflow_cnt = uflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, against a position-based model.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int M_HUNT = 0, M_WAIT = 1, M_SHOW = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_ready, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, frame_start;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [15:0] underflow_cnt;

  int total = 0, bad = 0;

  // model: raster position is just "edges since reset mod FRAME"
  int          pos = 0, m_mode = M_HUNT, uflow = 0;
  logic [15:0] held = '0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_blank = 1'b0, e_fs = 1'b0;
  logic [23:0] e_rgb = '0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .frame_start(frame_start),
    .underflow_cnt(underflow_cnt)
  );

  always #20 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  function automatic logic [23:0] exp565(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  function automatic bit pos_active(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit model_ready();
    if (m_mode == M_HUNT) return 1'b1;
    if (m_mode == M_WAIT) return 1'b0;
    return pos_active(pos) && (pos != 0);
  endfunction

  task automatic model_reset();
    pos = 0; m_mode = M_HUNT; uflow = 0; held = '0;
    e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_fs = 1'b0; e_rgb = '0;
  endtask

  task automatic model_edge();
    int h, v, mb;
    bit act, org, rdy;
    h = pos % HT; v = pos / HT;
    act = pos_active(pos); org = (pos == 0); rdy = model_ready(); mb = m_mode;
    e_hs    = !(h >= HA + HFP && h < HA + HFP + HSY);
    e_vs    = !(v >= VA + VFP && v < VA + VFP + VSY);
    e_fs    = org;
    e_blank = act && (mb == M_SHOW || (mb == M_WAIT && org));
    e_rgb   = '0;
    if (mb == M_HUNT) begin
      if (pix_valid && pix_sof) begin held = pix_data; m_mode = M_WAIT; end
    end else if (mb == M_WAIT) begin
      if (org) begin e_rgb = exp565(held); m_mode = M_SHOW; end
    end else if (rdy) begin
      if (!pix_valid) uflow = (uflow == 65535) ? uflow : uflow + 1;
      else if (pix_sof) begin held = pix_data; m_mode = M_WAIT; end
      else e_rgb = exp565(pix_data);
    end
    pos = (pos + 1) % FRAME;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
  endtask

  function automatic logic [44:0] obs_vec();
    return {VGA_HS, VGA_VS, VGA_BLANK_n, frame_start, pix_ready, VGA_R, VGA_G, VGA_B, underflow_cnt};
  endfunction

  function automatic logic [44:0] exp_vec();
    return {e_hs, e_vs, e_blank, e_fs, model_ready(), e_rgb, 16'(uflow)};
  endfunction

  function automatic logic [15:0] rand_pix();
    return 16'($urandom) | 16'h0821;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < 2 * FRAME && pos != target; g++) cycle();
  endtask

  task automatic test_reset();
    logic [44:0] rst_vec;
    rst_vec = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0};
    #2 reset_n = 1'b0;
    #3;
    total++;
    if (obs_vec() !== rst_vec) begin bad++; $display("FAIL reset_async got=%h want=%h", obs_vec(), rst_vec); end
    @(negedge clk);
    total++;
    if (obs_vec() !== rst_vec) begin bad++; $display("FAIL reset_held got=%h want=%h", obs_vec(), rst_vec); end
    total++;
    if (VGA_SYNC_n !== 1'b1 || VGA_CLK !== clk) begin
      bad++; $display("FAIL sync_clk got sync_n=%b vga_clk=%b want 1/%b", VGA_SYNC_n, VGA_CLK, clk);
    end
  endtask

  task automatic test_idle_timing();
    int hs_low = 0, vs_low = 0, blank_hi = 0, last_hf = -1, last_vf = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    do_reset();
    for (int k = 1; k <= 2 * FRAME; k++) begin
      cycle();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL idle_cycle k=%0d got=%h want=%h", k, obs_vec(), exp_vec()); end
      if (!VGA_HS) hs_low++;
      if (!VGA_VS) vs_low++;
      if (VGA_BLANK_n) blank_hi++;
      if (prev_hs && !VGA_HS) begin
        if (last_hf >= 0) begin
          total++;
          if (k - last_hf !== HT) begin bad++; $display("FAIL hs_period got=%0d want=%0d", k - last_hf, HT); end
        end
        last_hf = k;
      end
      if (prev_vs && !VGA_VS) begin
        if (last_vf >= 0) begin
          total++;
          if (k - last_vf !== FRAME) begin bad++; $display("FAIL vs_period got=%0d want=%0d", k - last_vf, FRAME); end
        end
        last_vf = k;
      end
      prev_hs = VGA_HS; prev_vs = VGA_VS;
    end
    total++;
    if (hs_low !== 2 * VT * HSY) begin bad++; $display("FAIL hs_low_count got=%0d want=%0d", hs_low, 2 * VT * HSY); end
    total++;
    if (vs_low !== 2 * VSY * HT) begin bad++; $display("FAIL vs_low_count got=%0d want=%0d", vs_low, 2 * VSY * HT); end
    total++;
    if (blank_hi !== 0) begin bad++; $display("FAIL idle_blank_high got=%0d want=0", blank_hi); end
  endtask

  task automatic test_stream();
    int red = 0, last_fs = -1, fs_cnt = 0;
    do_reset();
    pix_valid = 1'b1; pix_data = 16'hF800; pix_sof = 1'b1;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      cycle();
      pix_sof = 1'b0;
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL stream_cycle k=%0d got=%h want=%h", k, obs_vec(), exp_vec()); end
      if (k > FRAME && k <= 2 * FRAME && VGA_BLANK_n && {VGA_R, VGA_G, VGA_B} == 24'hFF0000) red++;
      if (frame_start) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          total++;
          if (k - last_fs !== FRAME) begin bad++; $display("FAIL fs_period got=%0d want=%0d", k - last_fs, FRAME); end
        end
        last_fs = k;
      end
    end
    total++;
    if (red !== HA * VA) begin bad++; $display("FAIL red_pixels got=%0d want=%0d", red, HA * VA); end
    total++;
    if (fs_cnt !== 3) begin bad++; $display("FAIL fs_count got=%0d want=3", fs_cnt); end
  endtask

  task automatic test_underflow();
    int dark = 0;
    pix_valid = 1'b1; pix_sof = 1'b0;
    run_to(2 * HT + 5);
    pix_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL uflow_cycle k=%0d got=%h want=%h", k, obs_vec(), exp_vec()); end
      if (VGA_BLANK_n && {VGA_R, VGA_G, VGA_B} == 24'h0) dark++;
    end
    total++;
    if (dark !== 5) begin bad++; $display("FAIL uflow_black got=%0d want=5", dark); end
    total++;
    if (underflow_cnt !== 16'd5) begin bad++; $display("FAIL uflow_count got=%0d want=5", underflow_cnt); end
    total++;
    if (pix_ready !== 1'b1) begin bad++; $display("FAIL uflow_still_run got ready=%b want=1", pix_ready); end
    pix_valid = 1'b1; pix_data = rand_pix();
    cycle();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL uflow_resume got=%h want=%h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_resync();
    logic [15:0] d;
    int lit = 0;
    pix_valid = 1'b1; pix_sof = 1'b0;
    run_to(3 * HT + 10);
    d = rand_pix();
    pix_data = d; pix_sof = 1'b1;
    cycle();
    pix_sof = 1'b0;
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL resync_take got=%h want=%h", obs_vec(), exp_vec()); end
    for (int g = 0; g < FRAME && pos != 0; g++) begin
      pix_data = rand_pix();
      cycle();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL resync_cycle got=%h want=%h", obs_vec(), exp_vec()); end
      if (VGA_BLANK_n || {VGA_R, VGA_G, VGA_B} != 24'h0) lit++;
    end
    total++;
    if (lit !== 0) begin bad++; $display("FAIL resync_dark got=%0d want=0", lit); end
    cycle();
    total++;
    if ({frame_start, VGA_R, VGA_G, VGA_B} !== {1'b1, exp565(d)}) begin
      bad++; $display("FAIL resync_first got=%h want=%h", {frame_start, VGA_R, VGA_G, VGA_B}, {1'b1, exp565(d)});
    end
  endtask

  task automatic test_random();
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = rand_pix();
    for (int k = 0; k < 4 * FRAME; k++) begin
      cycle();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random_cycle k=%0d got=%h want=%h", k, obs_vec(), exp_vec()); end
      pix_valid = ($urandom_range(0, 9) < 7);
      pix_sof   = pix_valid && ($urandom_range(0, 149) == 0);
      pix_data  = rand_pix();
    end
  endtask

  task automatic test_reset_midframe();
    int lit = 0;
    logic [44:0] rst_vec;
    rst_vec = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0};
    pix_valid = 1'b1; pix_sof = 1'b0;
    run_to(HT + 12);
    reset_n = 1'b0;
    #2;
    total++;
    if (obs_vec() !== rst_vec) begin bad++; $display("FAIL midframe_reset got=%h want=%h", obs_vec(), rst_vec); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int k = 1; k <= FRAME + 2; k++) begin
      pix_data = rand_pix();
      cycle();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL post_reset_cycle k=%0d got=%h want=%h", k, obs_vec(), exp_vec()); end
      if (k == 1) begin
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL post_reset_fs got=%b want=1", frame_start); end
      end
      if (VGA_BLANK_n) lit++;
    end
    total++;
    if (lit !== 0) begin bad++; $display("FAIL hold_discarded got=%0d lit cycles want=0", lit); end
  endtask

  initial begin
    test_reset();
    test_idle_timing();
    test_stream();
    test_underflow();
    test_resync();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
